perip_key_events: RTL and testbench
===================================

Name: perip_key_events

Overview:
- Parametrised key-activity peripheral for the synthesiser keyboard.
- Provides per-key press counters for NUM_KEYS debounced keys and a timestamped event FIFO of press/release edges.
- Raises an interrupt while events are pending.
- Sits on the CPU peripheral bus next to the key debouncer. The CPU reads events instead of polling counters.

Parameters:
NUM_KEYS, 4, number of key inputs (1..16)
COUNT_WIDTH, 16, width of each press counter (1..32), zero-extended on read
FIFO_DEPTH, 8, event FIFO entries (power of two, 2..64)
TS_WIDTH, 16, free-running timestamp width (1..20)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs  input  1  peripheral select
addr  input  5  register word address
rd  input  1  read strobe; one cycle per access
wr  input  1  write strobe; one cycle per access
wdata  input  32  write data
rdata  output  32  read data, combinational
irq  output  1  registered interrupt request
key_state  input  NUM_KEYS  debounced key levels, high = pressed

Behaviour:
- Reset: synchronous, active-high. On the clk edge with reset=1, all of the following clear to 0:
  - counters, key_prev, pending slots
  - FIFO pointers and FIFO count
  - timestamp, CTRL, OVF
  - irq
- Reset mid-operation discards pending and queued events.
- rdata = 0 whenever !(cs && rd).
- Edge detection:
  - Press = key_prev[i]=0 and key_state[i]=1. Release = the reverse.
  - key_prev updates every cycle.
- Timestamp: free-running TS_WIDTH counter, wraps. Each event captures its value in the edge-detect cycle.
- Counters:
  - A press increments count[i].
  - CTRL.SAT=1: hold at all-ones. SAT=0: wrap to 0.
  - Write to CLEAR (0x13): count[i] <= 0 for every wdata[i]=1. If a clear and a press on the same key coincide, the clear wins and the count is 0.
- Pending slots, one per key, each holding {type, ts}:
  - A press always fills the slot. A release fills it only when CTRL.REL_EN=1.
  - An edge arriving while the key's slot is occupied is dropped and sets OVF. The counter still increments.
- Arbiter:
  - Each cycle, the lowest-index occupied slot pushes one event into the FIFO and its slot is cleared in that cycle.
  - FIFO full: the slot is cleared, the event is dropped, OVF is set.
  - A slot freed in cycle N can accept an edge detected in cycle N+1.
- Event word: [31]=1 valid, [30]=1 press / 0 release, [29:24]=0, [23:20]=key index, [19:0]=timestamp zero-extended.
- FIFO pop:
  - Read of EVENT (0x11) with FIFO non-empty returns the head word and pops at that clk edge.
  - Empty FIFO returns 0 and pops nothing.
  - Push and pop in the same cycle are both honoured, including when full; count is unchanged.
- irq <= CTRL.IRQ_EN & (fifo_count != 0), evaluated on the pre-edge count. irq lags the count by one cycle.
- Register map (word addresses):
  - 0x00..0x0F: count[i]. Addresses i >= NUM_KEYS read 0xDEADBEEF.
  - 0x10 STATUS (RW1C): [31:16]=fifo_count, [2]=OVF (write 1 clears), [1]=full, [0]=empty. When a W1C and a new overflow coincide, the new overflow wins (OVF stays 1).
  - 0x11 EVENT: read-only with pop. Writes are ignored.
  - 0x12 CTRL (RW): [0]=IRQ_EN, [1]=REL_EN, [2]=SAT.
  - 0x13 CLEAR: write-only, reads 0.
  - 0x14 KEYS: live key_state, zero-extended.
  - Any other address reads 0xDEADBEEF. Writes to it are ignored.
- A read strobe without cs has no side effects.

Test Plan:
- Reset, then pulse key 2 high for 10 cycles with CTRL=1 -> count2=1; one EVENT word 0xC020_0000|ts; irq high one cycle after push; EVENT read pops; irq low one cycle later; next read returns 0.
- Keys 0 and 3 rise in the same cycle -> FIFO receives key 0 then key 3 on consecutive cycles; STATUS fifo_count=2; both timestamps equal.
- REL_EN=0: press/release key 1 three times -> count1=3, 3 press events. REL_EN=1: same stimulus -> 6 events alternating press/release.
- FIFO_DEPTH=8: 9 presses with no reads -> STATUS full=1, OVF=1, count=8. Write STATUS bit2=1 -> OVF=0. Pop on the cycle a push arrives while full -> fifo_count stays 8.
- COUNT_WIDTH=4, SAT=1: 20 presses -> count=15. SAT=0: 17 presses -> count=1. CLEAR write bit0 in the same cycle as a key-0 press -> count0=0, event still queued.
- Assert reset for one cycle with 3 events queued and a slot pending -> next cycle STATUS=0x0000_0001, irq=0, all counters 0, unmapped addr 0x1F reads 0xDEADBEEF.

Source files
------------

// File: rtl/perip_key_events.sv
// Key-activity peripheral: per-key press counters plus a timestamped FIFO of
// press/release events, read over the CPU peripheral bus, with an interrupt.
module perip_key_events #(
  parameter int NUM_KEYS    = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic [4:0]          addr,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                irq,
  input  logic [NUM_KEYS-1:0] key_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] A_STATUS = 5'h10;
  localparam logic [4:0] A_EVENT  = 5'h11;
  localparam logic [4:0] A_CTRL   = 5'h12;
  localparam logic [4:0] A_CLEAR  = 5'h13;
  localparam logic [4:0] A_KEYS   = 5'h14;

  localparam logic [31:0] BAD_ADDR = 32'hDEAD_BEEF;

  logic [COUNT_WIDTH-1:0] count [NUM_KEYS];
  logic [NUM_KEYS-1:0]    key_prev;
  logic [NUM_KEYS-1:0]    slot_valid;
  logic [NUM_KEYS-1:0]    slot_press;
  logic [TS_WIDTH-1:0]    slot_ts [NUM_KEYS];

  logic [31:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;

  logic [TS_WIDTH-1:0]    ts;
  logic [2:0]             ctrl;   // [0]=IRQ_EN [1]=REL_EN [2]=SAT
  logic                   ovf;

  logic                   rd_en;
  logic                   wr_en;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [NUM_KEYS-1:0]    press_vec;
  logic [NUM_KEYS-1:0]    want_slot;
  logic                   edge_ovf;
  logic                   arb_valid;
  logic [NUM_KEYS-1:0]    arb_grant;
  logic [3:0]             arb_idx;
  logic                   arb_press;
  logic [TS_WIDTH-1:0]    arb_ts;
  logic [31:0]            ev_word;
  logic                   unused_wdata;

  assign rd_en      = cs & rd;
  assign wr_en      = cs & wr;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop        = rd_en && (addr == A_EVENT) && !fifo_empty;

  assign press_vec = key_state & ~key_prev;
  assign want_slot = press_vec | ((key_prev & ~key_state) & {NUM_KEYS{ctrl[1]}});
  // An edge on a key whose slot is still occupied this cycle is lost.
  assign edge_ovf  = |(want_slot & slot_valid);

  // NOTE: every variable gets a default before any conditional assignment so
  // always_comb never infers a latch.
  always_comb begin
    arb_valid = 1'b0;
    arb_grant = '0;
    arb_idx   = '0;
    arb_press = 1'b0;
    arb_ts    = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (slot_valid[i]) begin
        arb_valid    = 1'b1;
        arb_grant    = '0;
        arb_grant[i] = 1'b1;
        arb_idx      = 4'(i);
        arb_press    = slot_press[i];
        arb_ts       = slot_ts[i];
      end
    end
  end

  assign ev_word = {1'b1, arb_press, 6'b0, arb_idx, 20'(arb_ts)};
  // A pop in the same cycle makes room, even when the FIFO is full.
  assign push    = arb_valid && (!fifo_full || pop);
  assign drop    = arb_valid && fifo_full && !pop;

  assign unused_wdata = ^wdata;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        count[i]   <= '0;
        slot_ts[i] <= '0;
      end
      key_prev   <= '0;
      slot_valid <= '0;
      slot_press <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ts         <= '0;
      ctrl       <= '0;
      ovf        <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ts       <= ts + 1'b1;
      key_prev <= key_state;

      for (int i = 0; i < NUM_KEYS; i++) begin
        if (wr_en && (addr == A_CLEAR) && wdata[i]) begin
          count[i] <= '0;
        end else if (press_vec[i] && !(ctrl[2] && (&count[i]))) begin
          count[i] <= count[i] + 1'b1;
        end
        if (want_slot[i] && !slot_valid[i]) begin
          slot_press[i] <= press_vec[i];
          slot_ts[i]    <= ts;
        end
      end
      // The granted slot was occupied, so it can never be refilled this cycle.
      slot_valid <= (slot_valid & ~arb_grant) | (want_slot & ~slot_valid);

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;

      if (drop || edge_ovf)                                ovf <= 1'b1;
      else if (wr_en && (addr == A_STATUS) && wdata[2])    ovf <= 1'b0;

      if (wr_en && (addr == A_CTRL)) ctrl <= wdata[2:0];

      irq <= ctrl[0] && !fifo_empty;
    end
  end

  // NOTE: storage is left unreset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ev_word;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (!addr[4]) begin
        rdata = BAD_ADDR;
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (addr[3:0] == 4'(i)) rdata = 32'(count[i]);
        end
      end else begin
        case (addr)
          A_STATUS: rdata = {16'(fifo_count), 13'b0, ovf, fifo_full, fifo_empty};
          A_EVENT:  rdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
          A_CTRL:   rdata = {29'b0, ctrl};
          A_CLEAR:  rdata = 32'h0;
          A_KEYS:   rdata = 32'(key_state);
          default:  rdata = BAD_ADDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perip_key_events.sv
// Bench for perip_key_events: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a queue-based model.
module tb_perip_key_events;

  localparam int NK = 4;
  localparam int CW = 4;
  localparam int FD = 8;
  localparam int TW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic [4:0]    addr;
  logic          rd;
  logic          wr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;
  logic [NK-1:0] key_state;

  always #5 clk = ~clk;

  perip_key_events #(
    .NUM_KEYS(NK), .COUNT_WIDTH(CW), .FIFO_DEPTH(FD), .TS_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata), .irq(irq), .key_state(key_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  int          m_cnt  [NK];
  bit          m_prev [NK];
  bit          pv     [NK];
  bit          pp     [NK];
  int          pts    [NK];
  logic [31:0] m_fifo [$];
  int          m_ts;
  bit [2:0]    m_ctrl;
  bit          m_ovf;
  bit          m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    int n;
    n = m_fifo.size();
    if (!(cs && rd)) return 32'h0;
    if (addr < 5'h10) return (int'(addr) < NK) ? 32'(m_cnt[int'(addr)]) : 32'hDEAD_BEEF;
    case (addr)
      5'h10: return {16'(n), 13'b0, m_ovf, (n == FD), (n == 0)};
      5'h11: return (n > 0) ? m_fifo[0] : 32'h0;
      5'h12: return {29'b0, m_ctrl};
      5'h13: return 32'h0;
      5'h14: return 32'(key_state);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Applies the behavioural rules for one clock edge to the model.
  task automatic model_step();
    int  pre, arb;
    bit  pop, drop, press, rel;
    logic [31:0] word;
    if (reset) begin
      for (int i = 0; i < NK; i++) begin
        m_cnt[i] = 0; m_prev[i] = 0; pv[i] = 0; pp[i] = 0; pts[i] = 0;
      end
      m_fifo.delete();
      m_ts = 0; m_ctrl = 0; m_ovf = 0; m_irq = 0;
      m_valid = 1'b1;
      return;
    end
    pre  = m_fifo.size();
    pop  = cs && rd && (addr == 5'h11) && (pre > 0);
    drop = 1'b0;
    arb  = -1;
    for (int i = 0; i < NK; i++) if (pv[i] && arb < 0) arb = i;
    if (pop) void'(m_fifo.pop_front());
    if (arb >= 0) begin
      word = 32'h8000_0000 | (pp[arb] ? 32'h4000_0000 : 32'h0) | (32'(arb) << 20) | 32'(pts[arb]);
      if (pre < FD || pop) m_fifo.push_back(word);
      else drop = 1'b1;
    end
    for (int i = 0; i < NK; i++) begin
      press = !m_prev[i] && key_state[i];
      rel   = m_prev[i] && !key_state[i];
      if (press) m_cnt[i] = m_ctrl[2] ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                                      : (m_cnt[i] + 1) % (CMAX + 1);
      if (cs && wr && addr == 5'h13 && wdata[i]) m_cnt[i] = 0;
      if (press || (rel && m_ctrl[1])) begin
        if (pv[i]) drop = 1'b1;
        else begin pv[i] = 1'b1; pp[i] = press; pts[i] = m_ts; end
      end
      m_prev[i] = key_state[i];
    end
    if (arb >= 0) pv[arb] = 1'b0;
    if (cs && wr && addr == 5'h10 && wdata[2]) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_irq = m_ctrl[0] && (pre > 0);
    if (cs && wr && addr == 5'h12) m_ctrl = wdata[2:0];
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  // One cycle: compare outputs against the model, then advance both.
  task automatic tick();
    #1;
    if (m_valid) begin
      check($sformatf("rdata@%02h", addr), rdata, exp_rdata());
      check("irq", 32'(irq), 32'(m_irq));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle();
    cs = 0; rd = 0; wr = 0; addr = '0; wdata = '0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cs = 1; wr = 1; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic rd_lit(input string name, input logic [4:0] a, input logic [31:0] exp);
    cs = 1; rd = 1; addr = a;
    #1 check(name, rdata, exp);
    tick();
    idle();
  endtask

  task automatic rd_get(input logic [4:0] a, output logic [31:0] v);
    cs = 1; rd = 1; addr = a;
    #1 v = rdata;
    tick();
    idle();
  endtask

  task automatic pulses(input int key, input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      key_state[key] = 1'b1; ticks(hi);
      key_state[key] = 1'b0; ticks(lo);
    end
  endtask

  initial begin
    logic [31:0] v;
    int r;
    idle();
    key_state = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Single press on key 2: timestamp 1 is the edge-detect cycle.
    wr_reg(5'h12, 32'h1);
    key_state = 4'b0100;
    ticks(10);
    key_state = 4'b0000;
    check("irq_after_push", 32'(irq), 32'h1);
    rd_lit("count2", 5'h02, 32'h1);
    rd_lit("event_key2", 5'h11, 32'hC020_0001);
    rd_lit("event_empty", 5'h11, 32'h0);
    check("irq_after_pop", 32'(irq), 32'h0);

    // Simultaneous presses on keys 0 and 3.
    key_state = 4'b1001;
    ticks(3);
    rd_lit("status_two", 5'h10, 32'h0002_0000);
    rd_get(5'h11, v); check("ev_first_hdr", 32'(v[31:20]), 32'hC00);
    rd_get(5'h11, v); check("ev_second_hdr", 32'(v[31:20]), 32'hC03);
    key_state = 4'b0000;
    ticks(2);

    // Release events disabled, then enabled.
    pulses(1, 3, 3, 3);
    rd_lit("count1_a", 5'h01, 32'h3);
    rd_lit("status_three", 5'h10, 32'h0003_0000);
    for (int i = 0; i < 3; i++) begin
      rd_get(5'h11, v); check("ev_press_only", 32'(v[31:20]), 32'hC01);
    end
    wr_reg(5'h12, 32'h3);
    pulses(1, 3, 3, 3);
    rd_lit("status_six", 5'h10, 32'h0006_0000);
    rd_lit("count1_b", 5'h01, 32'h6);
    for (int i = 0; i < 6; i++) begin
      rd_get(5'h11, v);
      check("ev_alternate", 32'(v[31:20]), (i % 2 == 0) ? 32'hC01 : 32'h801);
    end

    // Overflow with a full FIFO, W1C, and pop while full.
    wr_reg(5'h12, 32'h1);
    pulses(0, 9, 2, 2);
    rd_lit("status_full_ovf", 5'h10, 32'h0008_0006);
    wr_reg(5'h10, 32'h4);
    rd_lit("status_ovf_clr", 5'h10, 32'h0008_0002);
    key_state[1] = 1'b1;
    tick();
    rd_get(5'h11, v);
    rd_lit("status_pop_push_full", 5'h10, 32'h0008_0002);
    key_state[1] = 1'b0;
    tick();
    rd_lit("count0_a", 5'h00, 32'hA);
    for (int i = 0; i < 8; i++) rd_get(5'h11, v);
    rd_lit("status_drained", 5'h10, 32'h0000_0001);

    // Saturation, wrap, and clear colliding with a press.
    wr_reg(5'h13, 32'hF);
    wr_reg(5'h12, 32'h5);
    pulses(2, 20, 2, 2);
    rd_lit("count2_sat", 5'h02, 32'hF);
    wr_reg(5'h13, 32'h4);
    wr_reg(5'h12, 32'h1);
    pulses(2, 17, 2, 2);
    rd_lit("count2_wrap", 5'h02, 32'h1);
    for (int i = 0; i < 10; i++) rd_get(5'h11, v);
    wr_reg(5'h10, 32'h4);
    cs = 1; wr = 1; addr = 5'h13; wdata = 32'h1; key_state[0] = 1'b1;
    tick();
    idle();
    ticks(2);
    rd_lit("count0_clear_wins", 5'h00, 32'h0);
    rd_lit("status_clear_event", 5'h10, 32'h0001_0000);

    // Reset with queued events and a pending slot.
    key_state = 4'b0111;
    ticks(4);
    key_state = 4'b1111;
    tick();
    reset = 1'b1; key_state = '0;
    tick();
    reset = 1'b0;
    #1 check("irq_post_reset", 32'(irq), 32'h0);
    rd_lit("status_post_reset", 5'h10, 32'h0000_0001);
    for (int i = 0; i < NK; i++) rd_lit("count_post_reset", 5'(i), 32'h0);
    rd_lit("unmapped_1f", 5'h1F, 32'hDEAD_BEEF);
    rd_lit("unmapped_count5", 5'h05, 32'hDEAD_BEEF);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset = 1'b0;
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 7) == 0) key_state[k] = ~key_state[k];
      r = $urandom_range(0, 99);
      if (r < 40) begin
      end else if (r < 70) begin
        cs = 1; rd = 1;
        addr = ($urandom_range(0, 1) == 0) ? 5'h11 : 5'($urandom_range(0, 31));
      end else if (r < 88) begin
        cs = 1; wr = 1;
        case ($urandom_range(0, 3))
          0: addr = 5'h12;
          1: addr = 5'h10;
          2: addr = 5'h13;
          default: addr = 5'($urandom_range(0, 31));
        endcase
        wdata = (addr == 5'h13) ? 32'($urandom_range(0, 15)) | 32'hFFFF_0000 : $urandom;
      end else if (r < 98) begin
        rd = 1; wr = 1'($urandom_range(0, 1)); addr = 5'h11; wdata = $urandom;
      end else begin
        reset = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
